matavimo_valdiklis: RTL and testbench
=====================================

# matavimo_valdiklis

Measurement controller: the stage directly upstream of the coarse/fine summation stage. It turns synchronised start/stop events and delay-line thermometer snapshots into three values: a coarse period count (`grubus`), a start fine code (`teigiamas_f`) and a stop fine code (`neigiamas_f`). It then issues a one-clock `enable` pulse, and the downstream stage latches the time on the rising edge of that pulse. Outputs are stable for one full clock before `enable` rises.

## Interface
Parameters:
- `size_frontu`, default 8: width of the fine codes and of `grubus`.
- `ilgis_linijos`, default 255: number of delay-line taps. Must be ≤ 2**size_frontu−1.

Ports:
- `clk`, in, 1: single system clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `pradzia`, in, 1: start event, already synchronised, single-cycle.
- `pabaiga`, in, 1: stop event, already synchronised, single-cycle.
- `linija`, in, ilgis_linijos: thermometer snapshot of the delay line, valid every cycle. Bit 0 is nearest the event.
- `teigiamas_f`, out, size_frontu: start fine code.
- `neigiamas_f`, out, size_frontu: stop fine code.
- `grubus`, out, size_frontu: coarse clock-period count between start and stop.
- `enable`, out, 1: result strobe, one clock wide.
- `uzimtas`, out, 1: busy.
- `klaida`, out, 1: sticky timeout flag.

## Operation
- States: LAUKIA (idle), MATUOJA (counting), STABILU (data settle), STROBAS (enable high).
- Fine code = number of ones in `linija`, registered at the capture edge. Range 0..ilgis_linijos.
- LAUKIA:
  - `pradzia`=1: register start fine code into `teigiamas_f`, load coarse counter with 1, clear `klaida`, go to MATUOJA.
  - `pabaiga` alone is ignored.
  - `pradzia` and `pabaiga` in the same cycle: treat as start only.
- MATUOJA:
  - Counter increments by 1 every cycle in which `pabaiga`=0.
  - `pabaiga`=1: register stop fine code into `neigiamas_f`, load `grubus` with the current counter value, go to STABILU.
  - Resulting value: start at cycle s, stop at cycle e gives `grubus` = e−s.
  - `pradzia` in MATUOJA is ignored.
- Timeout: counter reaches 2**size_frontu−1 with no stop.
  - `klaida` goes to 1 and the block returns to LAUKIA.
  - No `enable` pulse; `grubus` and `neigiamas_f` are left unchanged.
  - `teigiamas_f` holds the new start code.
- STABILU: one cycle with `enable`=0; always goes to STROBAS.
- STROBAS: one cycle with `enable`=1; always goes to LAUKIA.
- `uzimtas`=1 in MATUOJA, STABILU and STROBAS; 0 in LAUKIA.
- `pradzia` is ignored in STABILU and STROBAS; a start is accepted again from the first LAUKIA cycle.
- Outputs hold their values until overwritten by the next measurement.
- Downstream, `teigiamas_f`−`neigiamas_f` may be negative. This block passes the codes unmodified.

## Timing
- Reset: state LAUKIA. `teigiamas_f`, `neigiamas_f`, `grubus`, `enable`, `uzimtas` and `klaida` are all 0; counter is 0.
- `rst` mid-measurement: abort at the next edge, no `enable`, all outputs 0.
- Stop in cycle e:
  - `neigiamas_f` and `grubus` update at the end of cycle e.
  - `enable`=1 during cycle e+2 only and returns to 0 in cycle e+3.
  - `uzimtas` falls at the start of cycle e+3.
- Minimum spacing between starts: start at cycle s, stop at cycle s+1 → earliest next start is cycle s+4.
- Conversion latency: the fine code is registered at the same edge that samples the event.

## Configuration
- Macro: `BUBBLE_FILTER_EN`.
- Defined: before the ones count, each tap bit is replaced by the 2-of-3 majority of itself and its two neighbours.
  - Below bit 0 is treated as 1; above the top bit is treated as 0.
  - The filter adds no latency.
- Undefined: raw ones count of `linija`.

## Test plan
- Basic measurement: reset, then `pradzia` with `linija` = 37 low ones; 6 cycles later `pabaiga` with 120 ones.
  - `teigiamas_f`=37, `neigiamas_f`=120, `grubus`=6.
  - `enable` high exactly in stop cycle+2; `uzimtas` low from stop cycle+3.
- Timeout: `pradzia`, then no stop for 255 cycles.
  - `klaida`=1, no `enable`, prior `grubus` unchanged.
  - Next `pradzia` clears `klaida`.
- Simultaneous events: `pradzia`=`pabaiga`=1 in idle, then `pabaiga` 3 cycles later → `grubus`=3, a single `enable` pulse.
- Reset mid-measurement: `rst` asserted 2 cycles into MATUOJA → all outputs 0 next cycle; a later `pabaiga` produces no `enable`.
- Ignored start: `pradzia` during STABILU is ignored; `pradzia` in the first LAUKIA cycle starts a new measurement.
- Bubble filter: `linija` with bits 0..9 set plus stray bit 20 set.
  - With `BUBBLE_FILTER_EN`: fine code = 10.
  - Without `BUBBLE_FILTER_EN`: fine code = 11.

Source files
------------

// File: rtl/matavimo_valdiklis.sv
// Measurement controller: turns start/stop events and delay-line snapshots into coarse/fine codes plus a result strobe.
// Optional macro BUBBLE_FILTER_EN enables a 2-of-3 majority filter on the thermometer taps before the ones count.
module matavimo_valdiklis #(
  parameter int size_frontu   = 8,
  parameter int ilgis_linijos = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pradzia,
  input  logic                     pabaiga,
  input  logic [ilgis_linijos-1:0] linija,
  output logic [size_frontu-1:0]   teigiamas_f,
  output logic [size_frontu-1:0]   neigiamas_f,
  output logic [size_frontu-1:0]   grubus,
  output logic                     enable,
  output logic                     uzimtas,
  output logic                     klaida
);

  typedef enum logic [1:0] {LAUKIA, MATUOJA, STABILU, STROBAS} busena_t;

  localparam logic [size_frontu-1:0] CNT_MAX = '1;

  busena_t                   r_busena;
  busena_t                   w_kita;
  logic                      w_start;
  logic                      w_stop;
  logic                      w_timeout;
  logic [ilgis_linijos-1:0]  w_linija;
  logic [size_frontu-1:0]    w_kodas;
  logic [size_frontu-1:0]    r_cnt;
  logic [size_frontu-1:0]    r_teig;
  logic [size_frontu-1:0]    r_neig;
  logic [size_frontu-1:0]    r_grubus;
  logic                      r_klaida;

  // Majority of each tap with its neighbours; below tap 0 reads as 1, above the top tap as 0.
  function automatic logic [ilgis_linijos-1:0] burbulu_filtras(input logic [ilgis_linijos-1:0] v);
    logic [ilgis_linijos+1:0] ext;
    logic [ilgis_linijos-1:0] f;
    ext = {1'b0, v, 1'b1};
    f   = '0;
    for (int i = 0; i < ilgis_linijos; i++) begin
      f[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    return f;
  endfunction

  function automatic logic [size_frontu-1:0] vienetu_sk(input logic [ilgis_linijos-1:0] v);
    logic [size_frontu-1:0] c;
    c = '0;
    for (int i = 0; i < ilgis_linijos; i++) begin
      c = c + size_frontu'(v[i]);
    end
    return c;
  endfunction

`ifdef BUBBLE_FILTER_EN
  assign w_linija = burbulu_filtras(linija);
`else
  assign w_linija = linija;
`endif

  assign w_kodas = vienetu_sk(w_linija);

  always_comb begin
    w_kita    = r_busena;
    w_start   = 1'b0;
    w_stop    = 1'b0;
    w_timeout = 1'b0;
    case (r_busena)
      LAUKIA: begin
        if (pradzia) begin
          w_start = 1'b1;
          w_kita  = MATUOJA;
        end
      end
      MATUOJA: begin
        if (pabaiga) begin
          w_stop = 1'b1;
          w_kita = STABILU;
        end else if (r_cnt == CNT_MAX) begin
          w_timeout = 1'b1;
          w_kita    = LAUKIA;
        end
      end
      STABILU: w_kita = STROBAS;
      STROBAS: w_kita = LAUKIA;
      default: w_kita = LAUKIA;
    endcase
  end

  // Result registers are cleared by reset too, so an aborted measurement leaves all outputs at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busena <= LAUKIA;
      r_cnt    <= '0;
      r_teig   <= '0;
      r_neig   <= '0;
      r_grubus <= '0;
      r_klaida <= 1'b0;
    end else begin
      r_busena <= w_kita;
      if (w_start) begin
        r_teig   <= w_kodas;
        r_cnt    <= size_frontu'(1);
        r_klaida <= 1'b0;
      end
      if (r_busena == MATUOJA && !pabaiga && !w_timeout) begin
        r_cnt <= r_cnt + size_frontu'(1);
      end
      if (w_stop) begin
        r_neig   <= w_kodas;
        r_grubus <= r_cnt;
      end
      if (w_timeout) begin
        r_klaida <= 1'b1;
      end
    end
  end

  assign teigiamas_f = r_teig;
  assign neigiamas_f = r_neig;
  assign grubus      = r_grubus;
  assign klaida      = r_klaida;
  assign enable      = (r_busena == STROBAS);
  assign uzimtas     = (r_busena != LAUKIA);

endmodule

// File: tb/tb_matavimo_valdiklis.sv
// Scoreboard bench for matavimo_valdiklis: expected results queued at stop, checked on each enable strobe.
module tb_matavimo_valdiklis;

  localparam int SF = 8;
  localparam int L  = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          pradzia;
  logic          pabaiga;
  logic [L-1:0]  linija;
  logic [SF-1:0] teigiamas_f;
  logic [SF-1:0] neigiamas_f;
  logic [SF-1:0] grubus;
  logic          enable;
  logic          uzimtas;
  logic          klaida;

  matavimo_valdiklis #(.size_frontu(SF), .ilgis_linijos(L)) dut (
    .clk(clk), .rst(rst), .pradzia(pradzia), .pabaiga(pabaiga), .linija(linija),
    .teigiamas_f(teigiamas_f), .neigiamas_f(neigiamas_f), .grubus(grubus),
    .enable(enable), .uzimtas(uzimtas), .klaida(klaida)
  );

  always #5 clk = ~clk;

  typedef struct {
    int teig;
    int neig;
    int grub;
    int ecyc;
  } laukiama_t;

  laukiama_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] therm(input int n);
    logic [L-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every enable must match a queued measurement and arrive in the expected cycle.
  always @(negedge clk) begin
    if (enable) begin
      if (q.size() == 0) begin
        chk("spurious_enable", 1, 0);
      end else begin
        laukiama_t e;
        e = q.pop_front();
        chk("sb_teigiamas_f", int'(teigiamas_f), e.teig);
        chk("sb_neigiamas_f", int'(neigiamas_f), e.neig);
        chk("sb_grubus", int'(grubus), e.grub);
        chk("sb_enable_cycle", cyc, e.ecyc);
      end
    end
  end

  // Drives start in the current cycle and stop k cycles later; returns with the bench in stop cycle + 1.
  task automatic measure(input logic [L-1:0] vs, input logic [L-1:0] ve,
                         input int exp_t, input int exp_n, input int k, input bit both);
    laukiama_t e;
    pradzia = 1'b1;
    pabaiga = both;
    linija  = vs;
    tick();
    pradzia = 1'b0;
    pabaiga = 1'b0;
    linija  = '0;
    for (int i = 1; i < k; i++) tick();
    pabaiga = 1'b1;
    linija  = ve;
    e.teig = exp_t;
    e.neig = exp_n;
    e.grub = k;
    e.ecyc = cyc + 2;
    q.push_back(e);
    tick();
    pabaiga = 1'b0;
    linija  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0] bub;
    int exp_bub;
    rst     = 1'b1;
    pradzia = 1'b0;
    pabaiga = 1'b0;
    linija  = '0;
    tick();
    tick();
    chk("rst_teig", int'(teigiamas_f), 0);
    chk("rst_neig", int'(neigiamas_f), 0);
    chk("rst_grubus", int'(grubus), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_uzimtas", int'(uzimtas), 0);
    chk("rst_klaida", int'(klaida), 0);
    rst = 1'b0;
    tick();

    // Basic measurement
    measure(therm(37), therm(120), 37, 120, 6, 1'b0);
    chk("basic_stab_busy", int'(uzimtas), 1);
    chk("basic_stab_enable", int'(enable), 0);
    chk("basic_grubus", int'(grubus), 6);
    chk("basic_neig", int'(neigiamas_f), 120);
    tick();
    chk("basic_strobe_enable", int'(enable), 1);
    chk("basic_strobe_busy", int'(uzimtas), 1);
    tick();
    chk("basic_after_enable", int'(enable), 0);
    chk("basic_after_busy", int'(uzimtas), 0);
    tick();

    // Timeout
    pradzia = 1'b1;
    linija  = therm(50);
    tick();
    pradzia = 1'b0;
    linija  = '0;
    chk("to_busy", int'(uzimtas), 1);
    for (int i = 0; i < 300; i++) tick();
    chk("to_klaida", int'(klaida), 1);
    chk("to_busy_after", int'(uzimtas), 0);
    chk("to_grubus_kept", int'(grubus), 6);
    chk("to_neig_kept", int'(neigiamas_f), 120);
    chk("to_teig_new", int'(teigiamas_f), 50);
    pradzia = 1'b1;
    linija  = therm(5);
    tick();
    pradzia = 1'b0;
    chk("to_klaida_cleared", int'(klaida), 0);
    for (int i = 1; i < 4; i++) tick();
    pabaiga = 1'b1;
    linija  = therm(9);
    begin
      laukiama_t e;
      e.teig = 5; e.neig = 9; e.grub = 4; e.ecyc = cyc + 2;
      q.push_back(e);
    end
    tick();
    pabaiga = 1'b0;
    linija  = '0;
    tick(); tick(); tick();

    // Simultaneous start and stop in idle
    measure(therm(10), therm(200), 10, 200, 3, 1'b1);
    tick(); tick(); tick();
    chk("simul_busy", int'(uzimtas), 0);

    // Reset mid-measurement
    pradzia = 1'b1;
    linija  = therm(60);
    tick();
    pradzia = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rmid_teig", int'(teigiamas_f), 0);
    chk("rmid_grubus", int'(grubus), 0);
    chk("rmid_neig", int'(neigiamas_f), 0);
    chk("rmid_busy", int'(uzimtas), 0);
    chk("rmid_enable", int'(enable), 0);
    rst = 1'b0;
    tick();
    pabaiga = 1'b1;
    linija  = therm(30);
    tick();
    pabaiga = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rmid_idle", int'(uzimtas), 0);

    // Start ignored in STABILU, accepted in first LAUKIA cycle
    measure(therm(1), therm(2), 1, 2, 1, 1'b0);
    pradzia = 1'b1;
    linija  = therm(99);
    tick();
    pradzia = 1'b0;
    tick();
    chk("ign_idle", int'(uzimtas), 0);
    chk("ign_teig", int'(teigiamas_f), 1);
    measure(therm(77), therm(255), 77, 255, 2, 1'b0);
    chk("ign_new_teig", int'(teigiamas_f), 77);
    tick(); tick(); tick();

    // Bubble filter
    bub = therm(10);
    bub[20] = 1'b1;
`ifdef BUBBLE_FILTER_EN
    exp_bub = 10;
`else
    exp_bub = 11;
`endif
    measure(bub, therm(3), exp_bub, 3, 4, 1'b0);
    chk("bub_teig", int'(teigiamas_f), exp_bub);
    tick(); tick(); tick();

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
